// File: rtl/menu_textbuf.sv
// menu_textbuf -- dual-port text buffer for an on-screen menu.
//
// Port A is the host port (read-first, latency 1); port B is the display read port
// (latency 1 + OREG). A clear engine fills a run of words with one value, one word per
// cycle, wrapping at the top of the buffer. The host port is locked out while filling.
//
// Parameters:
//   ADDR_W    word address width, DEPTH = 2**ADDR_W
//   DATA_W    word width
//   OREG      1 adds a port-B output register stage
//   INIT_FILE hex preload file handed to the RAM primitive; empty leaves the device
//             default (all-zero) power-up contents
//
// Ports:
//   clk, resetn                              clock, async active-low reset
//   a_ce, a_we, a_addr, a_din, a_dout        host access
//   a_ready                                  host access accepted (not filling)
//   b_ce, b_addr, b_dout, b_valid            display read
//   clr_start, clr_base, clr_len, clr_value  fill request
//   clr_busy, clr_done                       fill status
//
// Build option: define MENU_TEXTBUF_BYPASS_EN to forward a same-cycle port-A write
// (host or fill) to a port-B read of the same address. Undefined, port B sees old data.

module menu_textbuf #(
    parameter int unsigned ADDR_W    = 11,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned OREG      = 1,
    parameter string       INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              a_ce,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_din,
    output logic [DATA_W-1:0] a_dout,
    output logic              a_ready,
    input  logic              b_ce,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] b_dout,
    output logic              b_valid,
    input  logic              clr_start,
    input  logic [ADDR_W-1:0] clr_base,
    input  logic [ADDR_W:0]   clr_len,
    input  logic [DATA_W-1:0] clr_value,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam logic [ADDR_W:0] LenMax = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CntOne = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {StIdle, StFill, StDone} clr_state_e;

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
    logic [ADDR_W:0]   fill_cnt_q, fill_cnt_d;
    logic [DATA_W-1:0] fill_val_q, fill_val_d;
    logic [ADDR_W:0]   len_sat;

    (* ram_init_file = INIT_FILE *)
    logic [DATA_W-1:0] mem [2**ADDR_W];

    assign len_sat  = (clr_len > LenMax) ? LenMax : clr_len;
    assign clr_busy = (state_q == StFill);
    assign clr_done = (state_q == StDone);
    assign a_ready  = ~clr_busy;

    // Clear engine
    always_comb begin
        state_d     = state_q;
        fill_addr_d = fill_addr_q;
        fill_cnt_d  = fill_cnt_q;
        fill_val_d  = fill_val_q;
        unique case (state_q)
            StIdle: begin
                if (clr_start) begin
                    if (len_sat == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d     = StFill;
                        fill_addr_d = clr_base;
                        fill_cnt_d  = len_sat;
                        fill_val_d  = clr_value;
                    end
                end
            end
            StFill: begin
                // Address counter is ADDR_W wide, so it wraps modulo DEPTH by itself.
                fill_addr_d = fill_addr_q + ADDR_W'(1);
                fill_cnt_d  = fill_cnt_q - CntOne;
                if (fill_cnt_q == CntOne) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            fill_addr_q <= '0;
            fill_cnt_q  <= '0;
            fill_val_q  <= '0;
        end else begin
            state_q     <= state_d;
            fill_addr_q <= fill_addr_d;
            fill_cnt_q  <= fill_cnt_d;
            fill_val_q  <= fill_val_d;
        end
    end

    // Port A is shared between host and fill; the two never overlap since the host is
    // locked out while filling.
    logic              host_acc;
    logic              pa_we;
    logic [ADDR_W-1:0] pa_addr;
    logic [DATA_W-1:0] pa_wdata;
    logic [DATA_W-1:0] a_dout_q;

    assign host_acc = a_ce & ~clr_busy;
    assign pa_we    = clr_busy | (host_acc & a_we);
    assign pa_addr  = clr_busy ? fill_addr_q : a_addr;
    assign pa_wdata = clr_busy ? fill_val_q : a_din;

    always_ff @(posedge clk) begin
        if (pa_we) begin
            mem[pa_addr] <= pa_wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_dout_q <= '0;
        end else if (host_acc) begin
            a_dout_q <= mem[a_addr];
        end
    end

    assign a_dout = a_dout_q;

    // Port B
    logic [DATA_W-1:0] b_rdata;
    logic [DATA_W-1:0] b1_q;
    logic              bv1_q;

`ifdef MENU_TEXTBUF_BYPASS_EN
    assign b_rdata = (pa_we && (pa_addr == b_addr)) ? pa_wdata : mem[b_addr];
`else
    assign b_rdata = mem[b_addr];
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            b1_q  <= '0;
            bv1_q <= 1'b0;
        end else begin
            bv1_q <= b_ce;
            if (b_ce) begin
                b1_q <= b_rdata;
            end
        end
    end

    if (OREG != 0) begin : g_oreg
        logic [DATA_W-1:0] b2_q;
        logic              bv2_q;

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                b2_q  <= '0;
                bv2_q <= 1'b0;
            end else begin
                bv2_q <= bv1_q;
                if (bv1_q) begin
                    b2_q <= b1_q;
                end
            end
        end

        assign b_dout  = b2_q;
        assign b_valid = bv2_q;
    end else begin : g_no_oreg
        assign b_dout  = b1_q;
        assign b_valid = bv1_q;
    end

endmodule

// File: tb/tb_menu_textbuf.sv
module tb_menu_textbuf;

    localparam int AW    = 11;
    localparam int DW    = 8;
    localparam int DEPTH = 2048;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          a_ce = 1'b0, a_we = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_din = '0;
    logic [DW-1:0] a_dout;
    logic          a_ready;
    logic          b_ce = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_dout;
    logic          b_valid;
    logic          clr_start = 1'b0;
    logic [AW-1:0] clr_base = '0;
    logic [AW:0]   clr_len = '0;
    logic [DW-1:0] clr_value = '0;
    logic          clr_busy;
    logic          clr_done;

    always #5 clk = ~clk;

    menu_textbuf #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .OREG     (1),
        .INIT_FILE("")
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .a_ce     (a_ce),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_din    (a_din),
        .a_dout   (a_dout),
        .a_ready  (a_ready),
        .b_ce     (b_ce),
        .b_addr   (b_addr),
        .b_dout   (b_dout),
        .b_valid  (b_valid),
        .clr_start(clr_start),
        .clr_base (clr_base),
        .clr_len  (clr_len),
        .clr_value(clr_value),
        .clr_busy (clr_busy),
        .clr_done (clr_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: 0 idle, 1 fill, 2 done
    bit [DW-1:0]   m_mem [DEPTH];
    int            m_state = 0;
    logic [AW-1:0] m_addr = '0;
    int            m_cnt = 0;
    logic [DW-1:0] m_val = '0;
    logic [DW-1:0] m_adout = '0;
    logic [DW-1:0] m_bdout = '0;
    bit            m_bv1 = 1'b0, m_bv2 = 1'b0;
    logic [DW-1:0] b_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        a_ce = 1'b0;
        a_we = 1'b0;
        b_ce = 1'b0;
        clr_start = 1'b0;
    endtask

    // Called at a negedge with inputs set: check outputs, advance model, cross one edge.
    task automatic tick();
        logic [DW-1:0] bval, wdata, exp_b;
        logic [AW-1:0] waddr;
        bit            we, acc;
        int            l;

        check("a_ready", a_ready, m_state != 1);
        check("clr_busy", clr_busy, m_state == 1);
        check("clr_done", clr_done, m_state == 2);
        check("a_dout", a_dout, m_adout);
        check("b_valid", b_valid, m_bv2);
        if (b_valid && b_q.size() > 0) begin
            exp_b = b_q.pop_front();
            check("b_dout", b_dout, exp_b);
            m_bdout = exp_b;
        end else if (b_valid) begin
            check("b_valid_unexpected", b_valid, 0);
        end else begin
            check("b_dout_hold", b_dout, m_bdout);
        end

        acc   = a_ce && (m_state != 1);
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        if (m_state == 1) begin
            we = 1'b1; waddr = m_addr; wdata = m_val;
        end else if (acc && a_we) begin
            we = 1'b1; waddr = a_addr; wdata = a_din;
        end
        if (acc) m_adout = m_mem[a_addr];
        bval = m_mem[b_addr];
`ifdef MENU_TEXTBUF_BYPASS_EN
        if (we && waddr == b_addr) bval = wdata;
`endif
        if (b_ce) b_q.push_back(bval);
        m_bv2 = m_bv1;
        m_bv1 = b_ce;
        if (we) m_mem[waddr] = wdata;

        case (m_state)
            0: if (clr_start) begin
                l = (clr_len > DEPTH) ? DEPTH : int'(clr_len);
                if (l == 0) m_state = 2;
                else begin
                    m_state = 1; m_addr = clr_base; m_cnt = l; m_val = clr_value;
                end
            end
            1: begin
                m_addr = m_addr + 1'b1;
                m_cnt--;
                if (m_cnt == 0) m_state = 2;
            end
            default: m_state = 0;
        endcase

        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        idle();
        resetn = 1'b0;
        #1;
        m_state = 0; m_adout = '0; m_bdout = '0; m_bv1 = 1'b0; m_bv2 = 1'b0;
        b_q.delete();
        check("rst_a_dout", a_dout, 0);
        check("rst_b_dout", b_dout, 0);
        check("rst_b_valid", b_valid, 0);
        check("rst_clr_busy", clr_busy, 0);
        check("rst_clr_done", clr_done, 0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic host_wr(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        a_ce = 1'b1; a_we = 1'b1; a_addr = addr; a_din = data;
        tick();
        idle();
    endtask

    task automatic host_rd(input logic [AW-1:0] addr);
        a_ce = 1'b1; a_we = 1'b0; a_addr = addr;
        tick();
        idle();
    endtask

    task automatic b_rd(input logic [AW-1:0] addr);
        b_ce = 1'b1; b_addr = addr;
        tick();
        idle();
    endtask

    task automatic clr(input logic [AW-1:0] base, input logic [AW:0] len,
                       input logic [DW-1:0] val);
        clr_start = 1'b1; clr_base = base; clr_len = len; clr_value = val;
        tick();
        idle();
    endtask

    initial begin
        @(negedge clk);
        apply_reset();

        // Whole buffer to a known value (clr_len = DEPTH exactly)
        clr(11'h000, 12'd2048, 8'h00);
        run(2050);

        // Host write/read, then display read of the same word
        host_wr(11'h010, 8'h41);
        host_rd(11'h010);
        b_rd(11'h010);
        run(3);

        // Wrapping fill; host write in the start cycle completes, one during fill drops
        host_wr(11'h002, 8'h77);
        host_wr(11'h005, 8'h33);
        host_wr(11'h7FE, 8'h11);
        a_ce = 1'b1; a_we = 1'b1; a_addr = 11'h003; a_din = 8'h99;
        clr_start = 1'b1; clr_base = 11'h7FE; clr_len = 12'd4; clr_value = 8'h20;
        tick();
        idle();
        host_wr(11'h005, 8'hEE);
        clr(11'h100, 12'd3, 8'hFF);     // ignored: engine busy
        run(4);
        foreach (b_q[i]) ;
        host_rd(11'h7FE); host_rd(11'h7FF); host_rd(11'h000); host_rd(11'h001);
        host_rd(11'h002); host_rd(11'h003); host_rd(11'h005); host_rd(11'h100);
        b_rd(11'h7FF); b_rd(11'h001); b_rd(11'h002);
        run(3);

        // Zero-length fill
        clr(11'h010, 12'd0, 8'hAB);
        run(2);
        host_rd(11'h010);
        run(1);

        // Over-length request saturates to DEPTH
        clr(11'h400, 12'd4095, 8'h5A);
        run(2050);
        host_rd(11'h3FF); host_rd(11'h400); host_rd(11'h010);
        run(1);

        // Reset in the second fill cycle
        clr(11'h100, 12'd8, 8'hAA);
        tick();
        apply_reset();
        run(2);
        host_rd(11'h100); host_rd(11'h101); host_rd(11'h102); host_rd(11'h107);
        run(1);

        // Same-cycle host write and display read of one address
        host_wr(11'h020, 8'h12);
        a_ce = 1'b1; a_we = 1'b1; a_addr = 11'h020; a_din = 8'h55;
        b_ce = 1'b1; b_addr = 11'h020;
        tick();
        idle();
        b_rd(11'h020);
        run(3);

        // Fill colliding with display reads
        clr(11'h030, 12'd2, 8'hC3);
        b_ce = 1'b1; b_addr = 11'h030; tick();
        b_addr = 11'h031; tick();
        idle();
        run(3);

        // Random traffic over a small window
        for (int i = 0; i < 400; i++) begin
            a_ce      = 1'($urandom_range(0, 1));
            a_we      = 1'($urandom_range(0, 1));
            a_addr    = AW'($urandom_range(0, 15));
            a_din     = DW'($urandom);
            b_ce      = 1'($urandom_range(0, 1));
            b_addr    = AW'($urandom_range(0, 15));
            clr_start = ($urandom_range(0, 19) == 0);
            clr_base  = AW'($urandom_range(0, 15));
            clr_len   = (AW+1)'($urandom_range(0, 5));
            clr_value = DW'($urandom);
            tick();
        end
        idle();
        run(8);
        check("b_queue_drained", b_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/menu_textbuf.md
MENU_TEXTBUF -- requirements
Module: menu_textbuf

Interface
REQ-001 Parameter ADDR_W, default 11, word address width; DEPTH = 2**ADDR_W.
REQ-002 Parameter DATA_W, default 8, word width.
REQ-003 Parameter OREG, default 1, adds a port-B output register stage (0 or 1).
REQ-004 Parameter INIT_FILE, default "", hex preload file; empty means RAM powers up all-zero.
REQ-005 clk  in  1  single clock for all logic.
REQ-006 resetn  in  1  asynchronous, active-low reset.
REQ-007 a_ce  in  1  host port access strobe.
REQ-008 a_we  in  1  host write when a_ce=1.
REQ-009 a_addr  in  ADDR_W  host address.
REQ-010 a_din  in  DATA_W  host write data.
REQ-011 a_dout  out  DATA_W  host read data.
REQ-012 a_ready  out  1  host port accepts access.
REQ-013 b_ce  in  1  display read strobe.
REQ-014 b_addr  in  ADDR_W  display address.
REQ-015 b_dout  out  DATA_W  display read data.
REQ-016 b_valid  out  1  b_dout holds data of a b_ce read.
REQ-017 clr_start  in  1  one-cycle pulse, start fill.
REQ-018 clr_base  in  ADDR_W  first fill address.
REQ-019 clr_len  in  ADDR_W+1  words to fill, 0..DEPTH.
REQ-020 clr_value  in  DATA_W  fill word.
REQ-021 clr_busy  out  1  fill in progress.
REQ-022 clr_done  out  1  one-cycle pulse at fill completion.

Function
REQ-023 Storage SHALL be DEPTH x DATA_W, inferred as true dual-port block RAM; contents SHALL NOT be affected by resetn.
REQ-024 a_ready SHALL equal !clr_busy; a_ce while a_ready=0 SHALL be dropped with no write and no a_dout change.
REQ-025 Port A SHALL be read-first, latency 1: an accepted access registers mem[a_addr] (pre-write value) into a_dout; a_dout SHALL hold when no access.
REQ-026 Port B SHALL be read-only with latency 1+OREG; b_valid SHALL be b_ce delayed by the same latency; b_dout SHALL hold when b_valid=0.
REQ-027 Clear engine states: IDLE, FILL, DONE.
REQ-028 IDLE -> FILL on clr_start with clr_len>0: latch base, len, value; clr_busy=1 from next cycle.
REQ-029 IDLE -> DONE on clr_start with clr_len=0: no writes.
REQ-030 FILL SHALL write clr_value to one address per cycle, base, base+1, ..., wrapping modulo DEPTH, exactly len writes, then -> DONE.
REQ-031 DONE SHALL assert clr_done for one cycle, deassert clr_busy, return to IDLE.
REQ-032 clr_start outside IDLE SHALL be ignored.
REQ-033 Host access and clr_start in the same IDLE cycle: host access SHALL complete; fill begins next cycle.
REQ-034 clr_len > DEPTH SHALL be saturated to DEPTH.

Reset
REQ-035 On resetn low: a_dout=0, b_dout=0, b_valid=0, clr_busy=0, clr_done=0, FSM=IDLE, pipeline registers cleared.
REQ-036 Reset mid-fill SHALL abort the fill with no clr_done; already-written words SHALL retain fill value.

Configuration
REQ-037 Macro MENU_TEXTBUF_BYPASS_EN defined: a port-B read of the address written by port A (host or fill) in the same cycle SHALL return the new data.
REQ-038 MENU_TEXTBUF_BYPASS_EN undefined: that collision SHALL return the old data; no forwarding logic present.

Verification
REQ-039 Host write 0x41 to 0x010, then read 0x010 -> a_dout=0x41 one cycle after read strobe, a_ready=1 throughout.
REQ-040 OREG=1, b_ce at 0x010 for 1 cycle -> b_valid high exactly 2 cycles later with b_dout=0x41.
REQ-041 clr_start base=0x7FE, len=4, value=0x20 -> 0x7FE,0x7FF,0x000,0x001 =0x20, clr_busy 4 cycles, clr_done single pulse, 0x002 untouched.
REQ-042 Host write to 0x005 during fill -> dropped; a_dout unchanged; 0x005 keeps prior value.
REQ-043 clr_len=0 -> clr_done one pulse, clr_busy never high, no RAM change.
REQ-044 resetn low at 2nd fill cycle, len=8 -> outputs zero, no clr_done, exactly 1 or 2 words written; with bypass macro, same-cycle B read of host write 0x55 returns 0x55, without returns old value.
